pipe_flow_ctrl: RTL and testbench

Pipeline control sequencer for the 5-stage RV32I core. It sits beside the ID/EX stages and consumes the sign-extended immediate the immediate extender produces for the EX-stage instruction. It detects load-use hazards and raises stalls. On branch and jump resolution in EX it computes the redirect target and drives a timed flush of the younger stages. It also keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline constants: base opcodes and the flow-control state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } flow_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle later.
// Backpressure: none, inc is sampled every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Load-use stall and branch/jump redirect sequencer for the 5-stage core, with debug counters.
// Latency: stall/flush are same-cycle (Mealy); redirect_valid/redirect_pc one cycle after detection.
// Backpressure: none; stalls are issued to the pipeline, never received.
module pipe_flow_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int FLUSH_CYCLES      = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic            ex_br_taken,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            flush_if,
    output logic            flush_id,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int CTR_W = 8;

    flow_state_t      state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             stall_on, flush_on, redir_take;
    logic             uses_rs1, uses_rs2, load_use, redir;
    logic             ex_jal, ex_jalr, ex_branch;
    logic [XLEN-1:0]  jalr_sum, target;

    assign uses_rs1 = (id_opcode != OPC_LUI) && (id_opcode != OPC_AUIPC) && (id_opcode != OPC_JAL);
    assign uses_rs2 = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) || (id_opcode == OPC_BRANCH);

    assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

    assign ex_jal    = (ex_opcode == OPC_JAL);
    assign ex_jalr   = (ex_opcode == OPC_JALR);
    assign ex_branch = (ex_opcode == OPC_BRANCH);
    assign redir     = ex_valid && (ex_jal || ex_jalr || (ex_branch && ex_br_taken));

    // JALR targets are halfword-aligned by clearing bit 0 of the sum.
    assign jalr_sum = ex_rs1_val + ex_imm;
    assign target   = ex_jalr ? (jalr_sum & ~XLEN'(1)) : (ex_pc + ex_imm);

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        stall_on   = 1'b0;
        flush_on   = 1'b0;
        redir_take = 1'b0;
        case (state_q)
            RUN, STALL: begin
                if (redir) begin
                    // A resolved control transfer outranks any hazard on the same cycle.
                    flush_on   = 1'b1;
                    redir_take = 1'b1;
                    state_d    = FLUSH;
                    ctr_d      = CTR_W'(FLUSH_CYCLES - 1);
                end else if (state_q == RUN) begin
                    if (load_use) begin
                        stall_on = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            ctr_d   = CTR_W'(LOAD_STALL_CYCLES - 2);
                        end
                    end
                end else begin
                    stall_on = 1'b1;
                    if (ctr_q == '0) state_d = RUN;
                    else             ctr_d   = ctr_q - CTR_W'(1);
                end
            end
            FLUSH: begin
                // Wrong-path ID/EX contents are ignored while squashing.
                flush_on = 1'b1;
                if (ctr_q == '0) state_d = RUN;
                else             ctr_d   = ctr_q - CTR_W'(1);
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            stall_on   = 1'b0;
            flush_on   = 1'b0;
            redir_take = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            ctr_q          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state_q        <= state_d;
            ctr_q          <= ctr_d;
            redirect_valid <= redir_take;
            if (redir_take) redirect_pc <= target;
        end
    end

    assign stall_if  = stall_on;
    assign stall_id  = stall_on;
    assign flush_if  = flush_on;
    assign flush_id  = flush_on;
    assign bubble_ex = stall_on || flush_on;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_on),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir_take),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed hazard/redirect cases, randomized traffic and counter saturation
// against a remaining-cycles reference model.
module tb_pipe_flow_ctrl;

    localparam int XLEN = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int LOAD_STALL_CYCLES = 1;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = 65535;

    localparam logic [6:0] O_BRANCH = 7'b1100011, O_JAL = 7'b1101111, O_JALR = 7'b1100111,
                           O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                           O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_OPIMM = 7'b0010011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0, ex_valid = 1'b0, ex_is_load = 1'b0, ex_br_taken = 1'b0;
    logic [6:0] id_opcode = O_OPIMM, ex_opcode = O_OPIMM;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic [XLEN-1:0] ex_pc = '0, ex_imm = '0, ex_rs1_val = '0;
    logic stall_if, stall_id, bubble_ex, flush_if, flush_id, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Model: cycles of squash still owed, extra stall cycles owed, redirect issued last cycle.
    int m_flush_left = 0, m_stall_left = 0, m_scnt = 0, m_fcnt = 0;
    bit m_last_redir = 0;
    logic [XLEN-1:0] m_rpc = '0;

    pipe_flow_ctrl #(
        .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES),
        .LOAD_STALL_CYCLES(LOAD_STALL_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_br_taken(ex_br_taken),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if(flush_if), .flush_id(flush_id),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        bit r1, r2;
        r1 = !(id_opcode inside {O_LUI, O_AUIPC, O_JAL});
        r2 = id_opcode inside {O_OP, O_STORE, O_BRANCH};
        return id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
               ((r1 && id_rs1 == ex_rd) || (r2 && id_rs2 == ex_rd));
    endfunction

    function automatic bit m_redir();
        return ex_valid && (ex_opcode == O_JAL || ex_opcode == O_JALR ||
                            (ex_opcode == O_BRANCH && ex_br_taken));
    endfunction

    function automatic logic [XLEN-1:0] m_target();
        logic [XLEN-1:0] s;
        if (ex_opcode == O_JALR) begin
            s = ex_rs1_val + ex_imm;
            s[0] = 1'b0;
            return s;
        end
        return ex_pc + ex_imm;
    endfunction

    task automatic compare_now();
        bit ef, es;
        ef = 0;
        es = 0;
        if (!rst) begin
            if (m_flush_left > 0 || m_redir()) ef = 1;
            else if (m_stall_left > 0 || m_load_use()) es = 1;
        end
        chk("stall_if", 32'(stall_if), 32'(es));
        chk("stall_id", 32'(stall_id), 32'(es));
        chk("flush_if", 32'(flush_if), 32'(ef));
        chk("flush_id", 32'(flush_id), 32'(ef));
        chk("bubble_ex", 32'(bubble_ex), 32'(es | ef));
        chk("redirect_valid", 32'(redirect_valid), rst ? 32'd0 : 32'(m_last_redir));
        chk("redirect_pc", redirect_pc, rst ? 32'd0 : m_rpc);
        chk("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(m_fcnt));
    endtask

    task automatic model_edge();
        bit took;
        took = 0;
        if (rst) begin
            m_flush_left = 0; m_stall_left = 0; m_scnt = 0; m_fcnt = 0; m_rpc = '0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_redir()) begin
            took = 1;
            m_flush_left = FLUSH_CYCLES;
            m_stall_left = 0;
            m_rpc = m_target();
            if (m_fcnt < CNT_MAX) m_fcnt++;
        end else if (m_stall_left > 0 || m_load_use()) begin
            if (m_scnt < CNT_MAX) m_scnt++;
            if (m_stall_left > 0) m_stall_left--;
            else m_stall_left = LOAD_STALL_CYCLES - 1;
        end
        m_last_redir = took;
    endtask

    // Inputs are held from posedge+1 through the next posedge; outputs are compared on the negedge.
    task automatic step();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; ex_valid = 0; ex_is_load = 0; ex_br_taken = 0;
        id_opcode = O_OPIMM; ex_opcode = O_OPIMM; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    task automatic set_load_ex(input logic [4:0] rd);
        ex_valid = 1; ex_opcode = O_LOAD; ex_is_load = 1; ex_rd = rd; ex_br_taken = 0;
    endtask

    task automatic set_id(input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2);
        id_valid = 1; id_opcode = opc; id_rs1 = r1; id_rs2 = r2;
    endtask

    initial begin
        logic [CNT_W-1:0] sc_before, fc_before;
        logic [6:0] opcs [9];
        opcs = '{O_BRANCH, O_JAL, O_JALR, O_LOAD, O_STORE, O_OP, O_LUI, O_AUIPC, O_OPIMM};

        idle();
        step();
        step();
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_flush_if", 32'(flush_if), 32'h0);
        rst = 0;
        #1;
        chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset_redirect_valid", 32'(redirect_valid), 32'h0);

        // Load-use through rs1
        set_load_ex(5); set_id(O_OPIMM, 5, 0);
        #1; chk("lu_rs1_stall", 32'(stall_if), 32'h1);
        step();
        idle();
        #1; chk("lu_rs1_one_cycle", 32'(stall_if), 32'h0);
        chk("lu_rs1_cnt", 32'(stall_cnt), 32'h1);
        step();
        set_load_ex(0); set_id(O_OPIMM, 0, 0);
        #1; chk("lu_rd0_nostall", 32'(stall_if), 32'h0);
        step();

        // rs2 only matters for R/S/B formats
        set_load_ex(5); set_id(O_OPIMM, 1, 5);
        #1; chk("itype_rs2_ignored", 32'(stall_id), 32'h0);
        step();
        set_id(O_OP, 1, 5);
        #1; chk("op_rs2_stall", 32'(stall_id), 32'h1);
        step();
        idle();
        step();

        // Taken branch: 0x100 + -16
        ex_valid = 1; ex_opcode = O_BRANCH; ex_br_taken = 1; ex_pc = 32'h100; ex_imm = 32'hFFFFFFF0;
        #1; chk("br_flush_detect", 32'(flush_if), 32'h1);
        step();
        idle();
        #1; chk("br_redirect_valid", 32'(redirect_valid), 32'h1);
        chk("br_redirect_pc", redirect_pc, 32'h000000F0);
        chk("br_flush_c1", 32'(flush_id), 32'h1);
        step();
        chk("br_flush_c2", 32'(flush_if), 32'h1);
        chk("br_redirect_once", 32'(redirect_valid), 32'h0);
        step();
        chk("br_flush_done", 32'(flush_if), 32'h0);
        chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
        step();

        // JALR alignment and wrap
        ex_valid = 1; ex_opcode = O_JALR; ex_rs1_val = 32'h2003; ex_imm = 32'h4;
        step();
        idle();
        #1; chk("jalr_target", redirect_pc, 32'h2006);
        repeat (3) step();
        ex_valid = 1; ex_opcode = O_JALR; ex_rs1_val = 32'hFFFFFFFF; ex_imm = 32'h2;
        step();
        idle();
        #1; chk("jalr_wrap", redirect_pc, 32'h0);
        repeat (3) step();

        // Redirect beats a simultaneous load-use; wrong-path JAL during FLUSH is ignored
        sc_before = stall_cnt;
        fc_before = flush_cnt;
        ex_valid = 1; ex_opcode = O_JAL; ex_is_load = 1; ex_rd = 5; ex_pc = 32'h400; ex_imm = 32'h20;
        set_id(O_OPIMM, 5, 0);
        #1; chk("simul_no_stall", 32'(stall_if), 32'h0);
        step();
        chk("simul_stall_cnt", 32'(stall_cnt), 32'(sc_before));
        chk("simul_flush_cnt", 32'(flush_cnt), 32'(fc_before) + 32'd1);
        chk("simul_rpc", redirect_pc, 32'h420);
        step();
        chk("wrongpath_no_redirect", 32'(redirect_valid), 32'h0);
        idle();
        step();
        step();

        // Reset asserted in the second FLUSH cycle
        ex_valid = 1; ex_opcode = O_JAL; ex_pc = 32'h80; ex_imm = 32'h8;
        step();
        idle();
        step();
        rst = 1;
        #1;
        chk("rst_flush_if", 32'(flush_if), 32'h0);
        chk("rst_bubble_ex", 32'(bubble_ex), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        step();
        rst = 0;
        #1; chk("rst_run_idle", 32'(flush_if), 32'h0);
        set_load_ex(7); set_id(O_STORE, 1, 7);
        #1; chk("rst_run_stall", 32'(stall_if), 32'h1);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            id_valid = ($urandom_range(0, 9) < 8);
            ex_valid = ($urandom_range(0, 9) < 8);
            id_opcode = opcs[$urandom_range(0, 8)];
            ex_opcode = opcs[$urandom_range(0, 8)];
            ex_is_load = (ex_opcode == O_LOAD) ? 1'b1 : ($urandom_range(0, 9) == 0);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            ex_br_taken = 1'($urandom);
            ex_pc = $urandom;
            ex_imm = $urandom;
            ex_rs1_val = $urandom;
            step();
        end
        rst = 0;
        idle();
        repeat (4) step();

        // Counter saturation
        set_load_ex(3); set_id(O_OP, 3, 0);
        for (int i = 0; i < CNT_MAX + 4; i++) step();
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'h0000FFFF);
        step();
        chk("stall_cnt_held", 32'(stall_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
